// File: rtl/div_unit.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results from the last completion are held
// RUN   | one shift-subtract step per edge, WIDTH steps, quotient MSB-first
// FIX   | apply signs, load quotient/remainder outputs
// DONE  | single-cycle done pulse, always returns to IDLE
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             signed_q, signed_d;
  logic             sign_n_q, sign_n_d;
  logic             sign_d_q, sign_d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             fits;

  // Next-state, datapath step and output-register computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    signed_d = signed_q;
    sign_n_d = sign_n_q;
    sign_d_d = sign_d_q;
    quo_d    = quo_q;
    rmd_d    = rmd_q;
    dbz_d    = dbz_q;

    // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    rem_sh  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          signed_d = is_signed;
          sign_n_d = dividend[WIDTH-1];
          sign_d_d = divisor[WIDTH-1];
          // Magnitude of the most negative value is itself when read unsigned.
          dvd_d    = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d    = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
          rem_d    = '0;
          cnt_d    = '0;
          if (divisor == '0) begin
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = fits ? rem_sub : rem_sh;
        dvd_d = {dvd_q[WIDTH-2:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        quo_d   = (signed_q && (sign_n_q ^ sign_d_q)) ? -dvd_q : dvd_q;
        rmd_d   = (signed_q && sign_n_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Single state register; reset wins over everything, including start.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      signed_q <= 1'b0;
      sign_n_q <= 1'b0;
      sign_d_q <= 1'b0;
      quo_q    <= '0;
      rmd_q    <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      signed_q <= signed_d;
      sign_n_q <= sign_n_d;
      sign_d_q <= sign_d_d;
      quo_q    <= quo_d;
      rmd_q    <= rmd_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against a plain-arithmetic reference.
module tb_div_unit;

  localparam int W = 32;

  logic         clk1 = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk1 = ~clk1;

  // Count every cycle in which done is high.
  always @(posedge clk1) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit truncating division; result truncated to W bits.
  task automatic ref_div(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk1); #1;
  endtask

  // Pulse start at the next edge (edge N); returns just after edge N.
  task automatic issue(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
    is_signed = sg; dividend = a; divisor = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for done within a bound; returns the number of edges waited.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input bit sg, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic ez;
    int lat, d0;
    ref_div(sg, a, b, eq, er, ez);
    d0 = done_cnt;
    issue(sg, a, b);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, ".lat"}, 64'(lat), (b == '0) ? 64'd0 : 64'(W + 1));
    chk({tag, ".q"}, 64'(quotient), 64'(eq));
    chk({tag, ".r"}, 64'(remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ez));
    tick();
    chk({tag, ".done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, ".idle"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int lat, d0;
    logic [W-1:0] a, b;
    bit sg;

    repeat (3) tick();
    rst = 1'b0;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.q", 64'(quotient), 64'd0);
    chk("reset.r", 64'(remainder), 64'd0);
    chk("reset.dbz", 64'(div_by_zero), 64'd0);

    run_op("u20_4", 1'b0, 32'd20, 32'd4);
    run_op("s-20_3", 1'b1, 32'hFFFF_FFEC, 32'd3);
    chk("s-20_3.q_const", 64'(quotient), 64'hFFFF_FFFA);
    chk("s-20_3.r_const", 64'(remainder), 64'hFFFF_FFFE);
    run_op("s20_-3", 1'b1, 32'd20, 32'hFFFF_FFFD);
    chk("s20_-3.r_const", 64'(remainder), 64'd2);
    run_op("u7_0", 1'b0, 32'd7, 32'd0);
    run_op("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("smin_-1.q_const", 64'(quotient), 64'h8000_0000);
    run_op("umin_-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("umin_-1.r_const", 64'(remainder), 64'h8000_0000);
    run_op("s0_5", 1'b1, 32'd0, 32'hFFFF_FFFB);

    // Results hold while idle.
    repeat (7) tick();
    chk("hold.q", 64'(quotient), 64'd0);
    chk("hold.dbz", 64'(div_by_zero), 64'd0);

    // Re-pulse start while busy: second request is ignored.
    d0 = done_cnt;
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    issue(1'b0, 32'd9, 32'd3);
    wait_done(lat);
    chk("overlap.lat", 64'(lat), 64'(W + 1 - 10));
    chk("overlap.q", 64'(quotient), 64'd14);
    chk("overlap.r", 64'(remainder), 64'd2);
    repeat (5) tick();
    chk("overlap.done_once", 64'(done_cnt - d0), 64'd1);
    chk("overlap.idle", 64'(busy), 64'd0);

    // Start coinciding with done is ignored.
    d0 = done_cnt;
    issue(1'b0, 32'd50, 32'd5);
    wait_done(lat);
    chk("start_at_done.q", 64'(quotient), 64'd10);
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    tick();
    start = 1'b0;
    chk("start_at_done.busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("start_at_done.once", 64'(done_cnt - d0), 64'd1);
    chk("start_at_done.hold", 64'(quotient), 64'd10);

    // Reset aborts an operation in flight.
    d0 = done_cnt;
    issue(1'b0, 32'd100, 32'd7);
    repeat (14) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.q", 64'(quotient), 64'd0);
    chk("abort.r", 64'(remainder), 64'd0);
    chk("abort.dbz", 64'(div_by_zero), 64'd0);
    repeat (40) tick();
    chk("abort.no_done", 64'(done_cnt - d0), 64'd0);
    run_op("post_abort_9_3", 1'b0, 32'd9, 32'd3);

    // Randomised operations.
    for (int i = 0; i < 250; i++) begin
      sg = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = '1;
        2, 3: b = W'($urandom_range(1, 15));
        4: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 15) == 0) a = 32'd0;
      run_op($sformatf("rnd%0d", i), sg, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
